// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared synchronous-read memory: zero-latency grant,
// round-robin on ties, bounded ownership lock, and read-data return steering.
module mem_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(MAX_LOCK);

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    own;
  logic          last;
  logic [LW-1:0] lcnt;
  logic          rsel;
  logic          rvalid_q;
  logic          g0;
  logic          g1;

  // An owner whose lock budget is spent yields to a waiting master; an owner
  // that stops requesting is treated exactly like FREE.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (own == OWN0 && m0_req) begin
      if (m1_req && lcnt == LCNT_MAX) g1 = 1'b1;
      else                            g0 = 1'b1;
    end else if (own == OWN1 && m1_req) begin
      if (m0_req && lcnt == LCNT_MAX) g0 = 1'b1;
      else                            g1 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (last) g0 = 1'b1;
      else      g1 = 1'b1;
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
  end

  assign m0_gnt    = g0 & rst_n;
  assign m1_gnt    = g1 & rst_n;
  assign mem_en    = m0_gnt | m1_gnt;
  assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;

  assign m0_rvalid = rvalid_q & ~rsel;
  assign m1_rvalid = rvalid_q &  rsel;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  // A forced hand-over always goes to the non-owner, so the "already owner"
  // test below naturally restarts lcnt at 1; lcnt saturates while uncontested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own      <= FREE;
      last     <= 1'b1;
      lcnt     <= '0;
      rsel     <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
      if (m0_gnt | m1_gnt) rsel <= m1_gnt;
      if (m0_gnt) begin
        last <= 1'b0;
        if (m0_lock) begin
          own  <= OWN0;
          lcnt <= (own != OWN0) ? LW'(1) :
                  (lcnt == LCNT_MAX) ? lcnt : lcnt + LW'(1);
        end else begin
          own  <= FREE;
          lcnt <= '0;
        end
      end else if (m1_gnt) begin
        last <= 1'b1;
        if (m1_lock) begin
          own  <= OWN1;
          lcnt <= (own != OWN1) ? LW'(1) :
                  (lcnt == LCNT_MAX) ? lcnt : lcnt + LW'(1);
        end else begin
          own  <= FREE;
          lcnt <= '0;
        end
      end else if ((own == OWN0 && !m0_req) || (own == OWN1 && !m1_req)) begin
        own  <= FREE;
        lcnt <= '0;
      end
    end
  end

endmodule
